dlist_fetch: RTL and testbench

Display-list fetch engine for ANTIC, sitting between the DMA/memory interface and the display-list instruction translator. It owns the 16-bit display list counter (DLIST) and fetches display-list bytes on request (loadIR). Each fetched byte is presented as IR with a one-cycle IR_rdy strobe, and jump operands are consumed via loadDLISTL/loadDLISTH/DLISTjump/DLISTend. It also accepts CPU writes to the DLISTL/DLISTH hardware registers.

---
 rtl/dlist_fetch_pkg.sv | 22 ++
 rtl/dlist_fetch_if.sv | 25 ++
 rtl/dlist_fetch_edge_detect.sv | 16 +
 rtl/dlist_fetch.sv | 104 ++++++++++
 tb/tb_dlist_fetch.sv | 306 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dlist_fetch_pkg.sv
// Shared state encoding, reset default and counter increment for the display-list fetch engine.
// DLIST_1K_WRAP_EN: when defined, the DLIST increment stays inside the current 1 KB page.
package dlist_fetch_pkg;

    typedef enum logic [1:0] {
        DL_IDLE    = 2'd0,
        DL_REQ     = 2'd1,
        DL_PRESENT = 2'd2
    } dl_state_t;

    localparam logic [15:0] DLIST_RESET_DEFAULT = 16'h0000;

    function automatic logic [15:0] dlist_inc(input logic [15:0] d);
`ifdef DLIST_1K_WRAP_EN
        // ANTIC's counter only carries through bits 9:0; the page bits never change.
        return {d[15:10], d[9:0] + 10'd1};
`else
        return d + 16'd1;
`endif
    endfunction

endpackage

// File: rtl/dlist_fetch_if.sv
// DMA read port between the display-list fetch engine (master) and the memory arbiter (slave).
// Handshake: master raises dma_req with a stable dma_addr and holds both until the slave answers
// with a single-cycle dma_ack, during which dma_data is valid; dma_req drops on the following edge.
interface dlist_fetch_if #(
    parameter int ADDR_W = 16
);
    logic              dma_req;
    logic [ADDR_W-1:0] dma_addr;
    logic              dma_ack;
    logic [7:0]        dma_data;

    modport master (
        output dma_req,
        output dma_addr,
        input  dma_ack,
        input  dma_data
    );

    modport slave (
        input  dma_req,
        input  dma_addr,
        output dma_ack,
        output dma_data
    );
endinterface

// File: rtl/dlist_fetch_edge_detect.sv
// Registered rising-edge detector: rise is high in the first cycle d is sampled high.
module antic_edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic rise
);
    logic d_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) d_q <= 1'b0;
        else     d_q <= d;
    end

    assign rise = d & ~d_q;
endmodule

// File: rtl/dlist_fetch.sv
// ANTIC display-list fetch engine: owns DLIST, fetches list bytes over DMA and handles jumps/halts.
// DLIST_1K_WRAP_EN selects 1 KB-page wrapping of the counter increment (see dlist_fetch_pkg).
module dlist_fetch
    import dlist_fetch_pkg::*;
#(
    parameter logic [15:0] RESET_DLIST = DLIST_RESET_DEFAULT,
    parameter int          ADDR_W      = 16
) (
    input  logic          Fphi0,
    input  logic          RST,
    input  logic          loadIR,
    input  logic          loadDLISTL,
    input  logic          loadDLISTH,
    input  logic          DLISTjump,
    input  logic          DLISTend,
    input  logic          vblank,
    input  logic          dma_en,
    input  logic          cpu_wrL,
    input  logic          cpu_wrH,
    input  logic [7:0]    cpu_data,
    dlist_fetch_if.master dma,
    output logic [7:0]    IR,
    output logic          IR_rdy,
    output logic [15:0]   DLIST,
    output logic          halted
);
    dl_state_t         state;
    logic              req_q;
    logic [ADDR_W-1:0] addr_q;
    logic              skip_inc;
    logic [7:0]        jmp_l;
    logic [7:0]        jmp_h;
    logic              jump_rise;
    logic              end_rise;
    logic              vblank_rise;
    logic              fetch_done;
    logic              can_issue;
    logic [15:0]       dlist_next;

    antic_edge_detect u_jump_edge   (.clk(Fphi0), .rst(RST), .d(DLISTjump), .rise(jump_rise));
    antic_edge_detect u_end_edge    (.clk(Fphi0), .rst(RST), .d(DLISTend),  .rise(end_rise));
    antic_edge_detect u_vblank_edge (.clk(Fphi0), .rst(RST), .d(vblank),    .rise(vblank_rise));

    assign dma.dma_req  = req_q;
    assign dma.dma_addr = addr_q;

    assign fetch_done = (state == DL_REQ) && dma.dma_ack;
    // A DLISTend edge blocks a request in the same cycle it sets halted.
    assign can_issue  = loadIR && dma_en && !halted && !end_rise;

    // Priority: jump over CPU byte writes over the post-fetch increment.
    always_comb begin
        dlist_next = DLIST;
        if (fetch_done && !skip_inc && !jump_rise) dlist_next = dlist_inc(DLIST);
        if (cpu_wrL) dlist_next[7:0]  = cpu_data;
        if (cpu_wrH) dlist_next[15:8] = cpu_data;
        if (jump_rise) dlist_next = {jmp_h, jmp_l};
    end

    always_ff @(posedge Fphi0 or posedge RST) begin
        if (RST) begin
            state    <= DL_IDLE;
            req_q    <= 1'b0;
            addr_q   <= '0;
            IR       <= 8'h00;
            IR_rdy   <= 1'b0;
            DLIST    <= RESET_DLIST;
            jmp_l    <= 8'h00;
            jmp_h    <= 8'h00;
            halted   <= 1'b0;
            skip_inc <= 1'b0;
        end else begin
            DLIST  <= dlist_next;
            IR_rdy <= 1'b0;
            if (loadDLISTL) jmp_l <= IR;
            if (loadDLISTH) jmp_h <= IR;
            if (end_rise)         halted <= 1'b1;
            else if (vblank_rise) halted <= 1'b0;

            case (state)
                DL_IDLE: begin
                    if (can_issue) begin
                        state    <= DL_REQ;
                        req_q    <= 1'b1;
                        addr_q   <= ADDR_W'(DLIST);
                        skip_inc <= 1'b0;
                    end
                end
                DL_REQ: begin
                    // A jump landing mid-fetch owns DLIST; the fetch's increment is dropped.
                    if (jump_rise) skip_inc <= 1'b1;
                    if (dma.dma_ack) begin
                        IR     <= dma.dma_data;
                        req_q  <= 1'b0;
                        IR_rdy <= 1'b1;
                        state  <= DL_PRESENT;
                    end
                end
                DL_PRESENT: state <= DL_IDLE;
                default:    state <= DL_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dlist_fetch.sv
// Self-checking bench for dlist_fetch: directed scenarios plus random traffic against a behavioural model.
`timescale 1ns/1ps
module tb_dlist_fetch;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        loadIR = 0, loadDLISTL = 0, loadDLISTH = 0, DLISTjump = 0, DLISTend = 0;
    logic        vblank = 0, dma_en = 0, cpu_wrL = 0, cpu_wrH = 0;
    logic [7:0]  cpu_data = 8'h00;
    logic [7:0]  IR;
    logic        IR_rdy;
    logic [15:0] DLIST;
    logic        halted;

    dlist_fetch_if #(.ADDR_W(16)) dma ();

    dlist_fetch dut (
        .Fphi0(clk), .RST(rst), .loadIR(loadIR), .loadDLISTL(loadDLISTL), .loadDLISTH(loadDLISTH),
        .DLISTjump(DLISTjump), .DLISTend(DLISTend), .vblank(vblank), .dma_en(dma_en),
        .cpu_wrL(cpu_wrL), .cpu_wrH(cpu_wrH), .cpu_data(cpu_data), .dma(dma.master),
        .IR(IR), .IR_rdy(IR_rdy), .DLIST(DLIST), .halted(halted)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- memory slave ----------------
    logic [7:0] mem [0:65535];
    int  ack_delay = 0;
    bit  rand_delay = 0;
    int  cur_delay = 0;
    int  wait_cnt = 0;
    bit  in_req = 0;

    initial begin
        dma.dma_ack  = 1'b0;
        dma.dma_data = 8'h00;
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    end

    always @(negedge clk) begin
        if (rst || !dma.dma_req) begin
            dma.dma_ack = 1'b0;
            in_req = 0;
        end else begin
            if (!in_req) begin
                in_req = 1;
                wait_cnt = 0;
                cur_delay = rand_delay ? int'($urandom_range(0, 3)) : ack_delay;
            end
            if (wait_cnt >= cur_delay) begin
                dma.dma_ack  = 1'b1;
                dma.dma_data = mem[dma.dma_addr];
            end else begin
                dma.dma_ack = 1'b0;
                wait_cnt++;
            end
        end
    end

    // ---------------- behavioural model + scoreboard ----------------
    logic [7:0]  exp_q[$];
    logic        m_req, m_rdy, m_halted, m_skip, p_jump, p_end, p_vb;
    logic [15:0] m_addr, m_dlist;
    logic [7:0]  m_ir, m_jl, m_jh;
    logic        t_jr, t_er, t_vr, t_ack, t_issue;
    logic [15:0] t_d;

    function automatic logic [15:0] model_inc(input logic [15:0] d);
`ifdef DLIST_1K_WRAP_EN
        return (d & 16'hFC00) | ((d + 16'd1) & 16'h03FF);
`else
        return d + 16'd1;
`endif
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_req <= 0; m_rdy <= 0; m_halted <= 0; m_skip <= 0;
            p_jump <= 0; p_end <= 0; p_vb <= 0;
            m_addr <= 16'h0000; m_dlist <= 16'h0000;
            m_ir <= 8'h00; m_jl <= 8'h00; m_jh <= 8'h00;
            exp_q.delete();
        end else begin
            t_jr    = DLISTjump & ~p_jump;
            t_er    = DLISTend & ~p_end;
            t_vr    = vblank & ~p_vb;
            t_ack   = m_req & dma.dma_ack;
            t_issue = !m_req && !m_rdy && loadIR && dma_en && !m_halted && !t_er;
            t_d     = (t_ack && !m_skip && !t_jr) ? model_inc(m_dlist) : m_dlist;
            if (cpu_wrL) t_d[7:0]  = cpu_data;
            if (cpu_wrH) t_d[15:8] = cpu_data;
            if (t_jr)    t_d = {m_jh, m_jl};
            m_dlist <= t_d;
            p_jump <= DLISTjump; p_end <= DLISTend; p_vb <= vblank;
            if (loadDLISTL) m_jl <= m_ir;
            if (loadDLISTH) m_jh <= m_ir;
            if (t_ack) m_ir <= dma.dma_data;
            m_rdy <= t_ack;
            if (t_issue) begin
                m_req  <= 1'b1;
                m_addr <= m_dlist;
                m_skip <= 1'b0;
                exp_q.push_back(mem[m_dlist]);
            end else if (t_ack) begin
                m_req <= 1'b0;
            end
            if (m_req && t_jr) m_skip <= 1'b1;
            if (t_er)      m_halted <= 1'b1;
            else if (t_vr) m_halted <= 1'b0;
        end
    end

    int req_cycles = 0;
    int rdy_cycles = 0;

    always @(negedge clk) begin
        if (!rst) begin
            check("dma_req", {15'd0, dma.dma_req}, {15'd0, m_req});
            check("dma_addr", dma.dma_addr, m_addr);
            check("IR", {8'd0, IR}, {8'd0, m_ir});
            check("IR_rdy", {15'd0, IR_rdy}, {15'd0, m_rdy});
            check("DLIST", DLIST, m_dlist);
            check("halted", {15'd0, halted}, {15'd0, m_halted});
            if (dma.dma_req) req_cycles++;
            if (IR_rdy) begin
                rdy_cycles++;
                if (exp_q.size() == 0) check("ir_q_empty", {8'd0, IR}, 16'hFFFF);
                else check("ir_q", {8'd0, IR}, {8'd0, exp_q.pop_front()});
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_req();
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (dma.dma_req) return;
        end
        check("wait_req_timeout", 16'd0, 16'd1);
    endtask

    task automatic wait_rdy();
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (IR_rdy) return;
        end
        check("wait_rdy_timeout", 16'd0, 16'd1);
    endtask

    task automatic fetch_one();
        loadIR = 1;
        wait_rdy();
        loadIR = 0;
        cyc(1);
    endtask

    task automatic set_dlist(input logic [15:0] v);
        cpu_wrL = 1; cpu_data = v[7:0];
        cyc(1);
        cpu_wrL = 0; cpu_wrH = 1; cpu_data = v[15:8];
        cyc(1);
        cpu_wrH = 0;
    endtask

    // ---------------- directed + random stimulus ----------------
    initial begin
        rst = 1;
        cyc(3);
        check("rst_req", {15'd0, dma.dma_req}, 16'd0);
        check("rst_addr", dma.dma_addr, 16'h0000);
        check("rst_ir", {8'd0, IR}, 16'h0000);
        check("rst_rdy", {15'd0, IR_rdy}, 16'd0);
        check("rst_dlist", DLIST, 16'h0000);
        check("rst_halted", {15'd0, halted}, 16'd0);
        rst = 0;
        dma_en = 1;
        cyc(2);

        // 1: CPU-loaded start address, single zero-wait fetch
        set_dlist(16'h3020);
        mem[16'h3020] = 8'h70;
        loadIR = 1;
        wait_req();
        check("t1_addr", dma.dma_addr, 16'h3020);
        wait_rdy();
        loadIR = 0;
        check("t1_ir", {8'd0, IR}, 16'h0070);
        check("t1_dlist", DLIST, 16'h3021);
        cyc(2);

        // 2: JMP + halt until vblank
        set_dlist(16'h2000);
        mem[16'h2000] = 8'h41; mem[16'h2001] = 8'h00; mem[16'h2002] = 8'h9C;
        mem[16'h9C00] = 8'h5A;
        fetch_one();
        check("t2_op", {8'd0, IR}, 16'h0041);
        fetch_one();
        loadDLISTL = 1; cyc(1); loadDLISTL = 0;
        fetch_one();
        loadDLISTH = 1; cyc(1); loadDLISTH = 0;
        DLISTjump = 1; DLISTend = 1; cyc(1);
        DLISTjump = 0; DLISTend = 0;
        check("t2_dlist", DLIST, 16'h9C00);
        check("t2_halted", {15'd0, halted}, 16'd1);
        req_cycles = 0;
        loadIR = 1;
        cyc(8);
        check("t2_no_req", 16'(req_cycles), 16'd0);
        vblank = 1; cyc(1); vblank = 0;
        wait_req();
        check("t2_jmp_addr", dma.dma_addr, 16'h9C00);
        wait_rdy();
        loadIR = 0;
        check("t2_ir", {8'd0, IR}, 16'h005A);
        cyc(2);

        // 3: increment at the 1 KB boundary
        set_dlist(16'h07FF);
        fetch_one();
`ifdef DLIST_1K_WRAP_EN
        check("t3_wrap", DLIST, 16'h0400);
`else
        check("t3_wrap", DLIST, 16'h0800);
`endif

        // 4: slow memory, 5 wait cycles
        ack_delay = 5;
        cyc(1);
        req_cycles = 0; rdy_cycles = 0;
        fetch_one();
        cyc(2);
        check("t4_req_cycles", 16'(req_cycles), 16'd6);
        check("t4_rdy_once", 16'(rdy_cycles), 16'd1);
        ack_delay = 0;

        // 5: CPU write / jump colliding with the increment
        set_dlist(16'h1234);
        loadIR = 1;
        wait_req();
        cpu_wrL = 1; cpu_data = 8'h55; loadIR = 0;
        cyc(1);
        cpu_wrL = 0;
        check("t5_wr_inc", DLIST, 16'h1255);
        cyc(2);
        loadIR = 1;
        wait_req();
        cpu_wrL = 1; cpu_data = 8'hAA; DLISTjump = 1; loadIR = 0;
        cyc(1);
        cpu_wrL = 0; DLISTjump = 0;
        check("t5_jump_wins", DLIST, 16'h9C00);
        cyc(2);

        // 6: asynchronous reset during REQ
        ack_delay = 10;
        loadIR = 1;
        wait_req();
        #2 rst = 1;
        #1;
        check("t6_req", {15'd0, dma.dma_req}, 16'd0);
        check("t6_addr", dma.dma_addr, 16'h0000);
        check("t6_dlist", DLIST, 16'h0000);
        check("t6_ir", {8'd0, IR}, 16'h0000);
        loadIR = 0;
        ack_delay = 0;
        cyc(2);
        rst = 0;
        cyc(2);

        // random traffic
        rand_delay = 1;
        for (int i = 0; i < 800; i++) begin
            loadIR     = ($urandom_range(0, 9) < 7);
            dma_en     = ($urandom_range(0, 9) < 9);
            loadDLISTL = ($urandom_range(0, 9) == 0);
            loadDLISTH = ($urandom_range(0, 9) == 0);
            DLISTjump  = ($urandom_range(0, 19) == 0);
            DLISTend   = ($urandom_range(0, 29) == 0);
            vblank     = ($urandom_range(0, 19) == 0);
            cpu_wrL    = ($urandom_range(0, 19) == 0);
            cpu_wrH    = ($urandom_range(0, 19) == 0);
            cpu_data   = 8'($urandom);
            cyc(1);
        end
        loadIR = 0; loadDLISTL = 0; loadDLISTH = 0; DLISTjump = 0; DLISTend = 0;
        vblank = 0; cpu_wrL = 0; cpu_wrH = 0;
        cyc(10);
        check("final_q_drained", 16'(exp_q.size()), 16'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
